// File: rtl/mult_radix_ct.sv
// Sequential unsigned multiplier retiring RADIX_BITS multiplier bits per cycle; STEPS cycles (constant-time)
// or up to the multiplier MSB (early-exit). start is ignored while busy; no backpressure on finish/out.
module mult_radix_ct #(
  parameter int WIDTH      = 8,
  parameter int RADIX_BITS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    const_time,
  input  logic [WIDTH-1:0]                        in1,
  input  logic [WIDTH-1:0]                        in2,
  output logic [2*WIDTH-1:0]                      out,
  output logic                                    finish,
  output logic                                    busy,
  output logic [$clog2(WIDTH/RADIX_BITS+1)-1:0]   steps
);

  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int SW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state;
  logic [WIDTH-1:0] mreg;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [SW-1:0]    k;
  logic             mode;

  logic [PW-1:0]    digit;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_next;
  logic [WIDTH-1:0] mrest;
  logic             last;

  // mcand is pre-shifted by k*RADIX_BITS each step, so no variable shifter is needed
  assign digit    = {{(PW-RADIX_BITS){1'b0}}, mreg[RADIX_BITS-1:0]};
  assign pp       = mcand * digit;
  assign acc_next = acc + pp;
  assign mrest    = mreg >> RADIX_BITS;
  assign last     = (k == SW'(STEPS - 1)) || (!mode && (mrest == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mreg   <= '0;
      mcand  <= '0;
      acc    <= '0;
      k      <= '0;
      mode   <= 1'b0;
      out    <= '0;
      finish <= 1'b0;
      busy   <= 1'b0;
      steps  <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mreg  <= in1;
            mcand <= {{WIDTH{1'b0}}, in2};
            mode  <= const_time;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mreg  <= mrest;
          mcand <= mcand << RADIX_BITS;
          k     <= k + SW'(1);
          if (last) begin
            out    <= acc_next;
            steps  <= k + SW'(1);
            finish <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_radix_ct.sv
// Directed and random checks of mult_radix_ct at WIDTH=8, RADIX_BITS=2.
module tb_mult_radix_ct;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        const_time;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [15:0] out;
  logic        finish;
  logic        busy;
  logic [2:0]  steps;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_out;

  mult_radix_ct #(.WIDTH(8), .RADIX_BITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .const_time (const_time),
    .in1        (in1),
    .in2        (in2),
    .out        (out),
    .finish     (finish),
    .busy       (busy),
    .steps      (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_steps(input logic [7:0] a, input logic ct);
    int nb;
    int s;
    if (ct) return 4;
    nb = 0;
    for (int i = 0; i < 8; i++) if (a[i]) nb = i + 1;
    s = (nb + 1) / 2;
    if (s < 1) s = 1;
    return s;
  endfunction

  // Called #1 after an edge; returns #1 after the start edge E0.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic ct);
    in1 = a;
    in2 = b;
    const_time = ct;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts cycles until finish, checking that out holds the previous product meanwhile.
  task automatic wait_fin(input string tag, output int n, output int nbusy);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (finish) break;
      if (busy) nbusy++;
      chk({tag, "_hold"}, out, prev_out);
    end
    chk({tag, "_fin_seen"}, finish, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ct);
    int n;
    int nb;
    int es;
    es = exp_steps(a, ct);
    launch(a, b, ct);
    wait_fin(tag, n, nb);
    chk({tag, "_out"}, out, 32'(a) * 32'(b));
    chk({tag, "_steps"}, steps, es);
    chk({tag, "_lat"}, n, es);
    prev_out = out;
  endtask

  initial begin
    int n;
    int nb;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rc;

    rst_n = 1'b0;
    start = 1'b0;
    const_time = 1'b0;
    in1 = '0;
    in2 = '0;
    prev_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_steps", steps, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant-time 13x11
    launch(8'd13, 8'd11, 1'b1);
    wait_fin("ct13", n, nb);
    chk("ct13_lat", n, 4);
    chk("ct13_out", out, 143);
    chk("ct13_steps", steps, 4);
    chk("ct13_busycyc", nb, 4);
    chk("ct13_busy_at_fin", busy, 0);
    prev_out = out;
    @(posedge clk);
    #1;
    chk("ct13_pulse_one", finish, 0);
    chk("ct13_out_idle", out, 143);

    // Early exit
    run_op("ee3x200", 8'd3, 8'd200, 1'b0);
    chk("ee3x200_exact", out, 600);
    run_op("ee0x77", 8'd0, 8'd77, 1'b0);
    chk("ee0_steps1", steps, 1);
    run_op("ee255", 8'd255, 8'd255, 1'b0);
    chk("ee255_exact", out, 65025);
    run_op("ee16x9", 8'd16, 8'd9, 1'b0);
    chk("ee16x9_steps3", steps, 3);

    // Start while busy is ignored
    launch(8'd13, 8'd11, 1'b1);
    @(posedge clk);
    #1;
    in1 = 8'd5;
    in2 = 8'd5;
    const_time = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ign_busy", busy, 1);
    wait_fin("ign", n, nb);
    chk("ign_lat", n + 2, 4);
    chk("ign_out", out, 143);
    chk("ign_steps", steps, 4);
    prev_out = out;

    // Back-to-back: start during the finish cycle
    launch(8'd2, 8'd7, 1'b1);
    chk("b2b_busy", busy, 1);
    chk("b2b_out_held", out, 143);
    wait_fin("b2b", n, nb);
    chk("b2b_lat", n, 4);
    chk("b2b_out", out, 14);
    prev_out = out;

    // Reset mid-operation
    launch(8'd13, 8'd11, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_out", out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_steps", steps, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("mrst_nofin", finish, 0);
    end
    rst_n = 1'b1;
    prev_out = '0;
    @(posedge clk);
    #1;
    chk("mrst_still_idle", finish, 0);
    run_op("post6x7", 8'd6, 8'd7, 1'b1);
    chk("post6x7_exact", out, 42);

    // Random regression in both modes
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      run_op(rc ? "rnd_ct" : "rnd_ee", ra, rb, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
